axis_vote_result_fifo: RTL and testbench

//  Output buffer placed directly after the majority-vote stage. It accepts the voted AXI-Stream

---
 rtl/axis_vote_result_fifo.sv | 85 ++++++++
 tb/tb_axis_vote_result_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axis_vote_result_fifo.sv
// FWFT result buffer behind the majority-vote stage, with wrap-around delivered-beat
// and delivered-packet counters for throughput monitoring.
module axis_vote_result_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int AF_LEVEL    = 14,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  input  logic                     stat_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic [COUNT_WIDTH-1:0]   word_count,
  output logic [COUNT_WIDTH-1:0]   pkt_count
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [ADDR_W:0]    wr_ptr, rd_ptr;
  logic               empty, full, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // tready depends only on stored state, so no path from m_axis_tready.
  assign s_axis_tready = !full;
  assign m_axis_tvalid = !empty;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  assign head          = mem[rd_ptr[ADDR_W-1:0]];
  assign m_axis_tdata  = head.data;
  assign m_axis_tlast  = head.last;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= '{last: s_axis_tlast, data: s_axis_tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  assign almost_full = (level >= LVL_W'(AF_LEVEL));

  // Clear wins over a same-cycle pop: that beat is deliberately not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
      pkt_count  <= '0;
    end else if (stat_clr) begin
      word_count <= '0;
      pkt_count  <= '0;
    end else if (pop) begin
      word_count <= word_count + COUNT_WIDTH'(1);
      pkt_count  <= pkt_count + COUNT_WIDTH'(head.last);
    end
  end

endmodule

// File: tb/tb_axis_vote_result_fifo.sv
// Randomized bench for axis_vote_result_fifo against a queue-based reference model;
// a second instance with 4-bit counters exercises counter wrap on the same stimulus.
module tb_axis_vote_result_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, m_tready, stat_clr;
  logic          s_tready, m_tvalid, m_tlast, af;
  logic [DW-1:0] m_tdata;
  logic [4:0]    level;
  logic [31:0]   wc, pc;

  logic          s_tready4, m_tvalid4, m_tlast4, af4;
  logic [DW-1:0] m_tdata4;
  logic [4:0]    level4;
  logic [3:0]    wc4, pc4;

  always #5 clk = ~clk;

  axis_vote_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .stat_clr(stat_clr), .level(level), .almost_full(af), .word_count(wc), .pkt_count(pc)
  );

  axis_vote_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready4), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast4),
    .stat_clr(stat_clr), .level(level4), .almost_full(af4), .word_count(wc4), .pkt_count(pc4)
  );

  typedef struct {
    logic          l;
    logic [DW-1:0] d;
  } beat_t;

  beat_t       q[$];
  logic [31:0] mwc, mpc;
  int          total, bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("m_tvalid", 64'(m_tvalid), 64'(q.size() > 0));
    chk("s_tready", 64'(s_tready), 64'(q.size() < DEPTH));
    chk("level", 64'(level), 64'(q.size()));
    chk("almost_full", 64'(af), 64'(q.size() >= AF));
    chk("word_count", 64'(wc), 64'(mwc));
    chk("pkt_count", 64'(pc), 64'(mpc));
    chk("word_count4", 64'(wc4), 64'(mwc % 16));
    chk("pkt_count4", 64'(pc4), 64'(mpc % 16));
    if (q.size() > 0) begin
      chk("m_tdata", 64'(m_tdata), 64'(q[0].d));
      chk("m_tlast", 64'(m_tlast), 64'(q[0].l));
    end
  endtask

  // One clock: drive, let the model decide push/pop from its own occupancy, update, compare.
  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic sl,
                      input logic mr, input logic clr);
    logic  do_push, do_pop;
    beat_t hd;
    s_tvalid = sv; s_tdata = sd; s_tlast = sl; m_tready = mr; stat_clr = clr;
    do_push = sv && (q.size() < DEPTH);
    do_pop  = mr && (q.size() > 0);
    if (do_pop) hd = q[0];
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (clr) begin
      mwc = 0; mpc = 0;
    end else if (do_pop) begin
      mwc = mwc + 1;
      mpc = mpc + 32'(hd.l);
    end
    if (do_push) q.push_back('{l: sl, d: sd});
    #1;
    check_all();
  endtask

  task automatic drain();
    while (q.size() > 0) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int idx;
    logic sv, mr;
    total = 0; bad = 0; mwc = 0; mpc = 0;
    rst = 1'b1; s_tvalid = 0; s_tdata = '0; s_tlast = 0; m_tready = 0; stat_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // single all-ones one-beat packet
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    chk("t1_data", 64'(m_tdata), 64'hFFFF_FFFF);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t1_wc", 64'(wc), 64'd1);
    chk("t1_pc", 64'(pc), 64'd1);

    // fill to full with sink stalled, 17th beat must stall
    for (int i = 0; i < 17; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      if (i == 12) chk("t2_af_13", 64'(af), 64'd0);
      if (i == 13) chk("t2_af_14", 64'(af), 64'd1);
    end
    chk("t2_full_lvl", 64'(level), 64'd16);
    chk("t2_full_rdy", 64'(s_tready), 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 64'(m_tdata), 64'(i));
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    chk("t2_empty", 64'(level), 64'd0);

    // hold level 8 under simultaneous push/pop
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 8; i < 28; i++) begin
      step(1'b1, 32'h100 + DW'(i), 1'b0, 1'b1, 1'b0);
      chk("t3_level", 64'(level), 64'd8);
    end
    drain();

    // five 3-beat packets under random backpressure
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idx = 0;
    while (idx < 15 || q.size() > 0) begin
      sv = (idx < 15) && ($urandom_range(0, 3) != 0);
      mr = $urandom_range(0, 1) == 1;
      step(sv, 32'h200 + DW'(idx), (idx % 3) == 2, mr, 1'b0);
      if (sv && q.size() <= DEPTH) idx++;
    end
    chk("t4_wc", 64'(wc), 64'd15);
    chk("t4_pc", 64'(pc), 64'd5);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + DW'(i), i == 2, 1'b0, 1'b0);
    while (q.size() > 1) step(1'b0, '0, 1'b0, $urandom_range(0, 1) == 1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("t4_clr_wc", 64'(wc), 64'd0);
    chk("t4_clr_pc", 64'(pc), 64'd0);

    // reset mid-stream at level 5
    for (int i = 0; i < 5; i++) step(1'b1, 32'h400 + DW'(i), 1'b0, 1'b0, 1'b0);
    chk("t5_lvl5", 64'(level), 64'd5);
    rst = 1'b1;
    #1;
    q.delete(); mwc = 0; mpc = 0;
    chk("t5_rst_valid", 64'(m_tvalid), 64'd0);
    chk("t5_rst_level", 64'(level), 64'd0);
    chk("t5_rst_rdy", 64'(s_tready), 64'd1);
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0);
    chk("t5_first", 64'(m_tdata), 64'hA5A5_A5A5);
    drain();

    // 17 single-beat packets: 4-bit counters wrap to 1
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t6_wc4", 64'(wc4), 64'd1);
    chk("t6_pc4", 64'(pc4), 64'd1);
    chk("t6_wc32", 64'(wc), 64'd17);

    // free-running random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
